// File: rtl/autocorr_pkg.sv
// autocorr_pkg
// Shared definitions for the autocorrelation controller slice.
//   SAMPLE_W : width of one deserialized sample word
//   state_t  : top-level run sequencing (IDLE, FILL, COMPUTE, DONE)
//   phase_t  : COMPUTE sub-phase (MAC accumulates, EMIT presents a lag)
//   lagWidth : width of a lag index, never narrower than one bit
package autocorr_pkg;

    localparam int SAMPLE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COMPUTE,
        DONE
    } state_t;

    typedef enum logic {
        MAC,
        EMIT
    } phase_t;

    function automatic int lagWidth(input int maxLag);
        return (maxLag > 1) ? $clog2(maxLag) : 1;
    endfunction

endpackage

// File: rtl/autocorr_sample_buf.sv
// autocorr_sample_buf
// N-entry sample window: one synchronous write port, two combinational
// read ports so the MAC can fetch x[n] and x[n-k] in the same cycle.
// Ports:
//   i_clk                 : clock
//   i_we, i_waddr, i_wdata: write port
//   i_raddr_a, o_rdata_a  : read port A (x[n])
//   i_raddr_b, o_rdata_b  : read port B (x[n-k])
module autocorr_sample_buf
    import autocorr_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_waddr,
    input  logic [SAMPLE_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]    i_raddr_a,
    input  logic [IDX_W-1:0]    i_raddr_b,
    output logic [SAMPLE_W-1:0] o_rdata_a,
    output logic [SAMPLE_W-1:0] o_rdata_b
);

    logic [SAMPLE_W-1:0] r_mem [N];

    // Contents are deliberately not reset: the window survives DONE and is
    // simply overwritten by the next run before it is read again.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/autocorr_controller.sv
// autocorr_controller
// Captures N strobed sample words after i_start, then computes lags
// R[0..MAX_LAG-1] with one time-shared multiply-accumulate and streams
// each lag out with a one-cycle valid, followed by a one-cycle done.
// Ports:
//   i_clk, i_rst_n        : clock, synchronous active-low reset
//   i_start               : begin a run (honoured only in IDLE)
//   i_word_in, i_word_valid: sample word and its one-cycle strobe
//   o_busy                : high while filling or computing
//   o_result, o_result_lag: last emitted R[k] and its lag k
//   o_result_valid        : one-cycle pulse per emitted lag
//   o_done                : one-cycle pulse after the final lag
//   o_overrun             : sticky, a strobe arrived while computing
module autocorr_controller
    import autocorr_pkg::*;
#(
    parameter int N       = 8,
    parameter int MAX_LAG = 4,
    parameter int ACC_W   = 2 * SAMPLE_W + $clog2(N),
    parameter int LAG_W   = lagWidth(MAX_LAG)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [SAMPLE_W-1:0] i_word_in,
    input  logic                i_word_valid,
    output logic                o_busy,
    output logic [ACC_W-1:0]    o_result,
    output logic [LAG_W-1:0]    o_result_lag,
    output logic                o_result_valid,
    output logic                o_done,
    output logic                o_overrun
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(MAX_LAG - 1);

    state_t              r_state;
    phase_t              r_phase;
    logic [IDX_W-1:0]    r_wptr;
    logic [IDX_W-1:0]    r_n;
    logic [LAG_W-1:0]    r_k;
    logic [ACC_W-1:0]    r_acc;
    logic                r_busy;
    logic [ACC_W-1:0]    r_result;
    logic [LAG_W-1:0]    r_result_lag;
    logic                r_result_valid;
    logic                r_done;
    logic                r_overrun;

    logic                w_we;
    logic [IDX_W-1:0]    w_raddr_b;
    logic [SAMPLE_W-1:0] w_xa;
    logic [SAMPLE_W-1:0] w_xb;
    logic [ACC_W-1:0]    w_prod;

    // Only strobes seen in FILL reach the window; the strobe coincident with
    // an accepted start arrives while still in IDLE and is therefore dropped.
    assign w_we      = (r_state == FILL) && i_word_valid;
    assign w_raddr_b = r_n - IDX_W'(r_k);
    assign w_prod    = ACC_W'(w_xa) * ACC_W'(w_xb);

    autocorr_sample_buf #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_buf (
        .i_clk     (i_clk),
        .i_we      (w_we),
        .i_waddr   (r_wptr),
        .i_wdata   (i_word_in),
        .i_raddr_a (r_n),
        .i_raddr_b (w_raddr_b),
        .o_rdata_a (w_xa),
        .o_rdata_b (w_xb)
    );

    // Run sequencer. Each lag spends N-k cycles in MAC (n walks k..N-1) and
    // one cycle in EMIT, where the finished sum is registered onto the
    // outputs and the accumulator is cleared for the next lag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_phase        <= MAC;
            r_wptr         <= '0;
            r_n            <= '0;
            r_k            <= '0;
            r_acc          <= '0;
            r_busy         <= 1'b0;
            r_result       <= '0;
            r_result_lag   <= '0;
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= FILL;
                        r_wptr    <= '0;
                        r_overrun <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                FILL: begin
                    if (i_word_valid) begin
                        r_wptr <= r_wptr + IDX_W'(1);
                        if (r_wptr == LAST_IDX) begin
                            r_state <= COMPUTE;
                            r_phase <= MAC;
                            r_k     <= '0;
                            r_n     <= '0;
                            r_acc   <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    if (i_word_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_phase == MAC) begin
                        r_acc <= r_acc + w_prod;
                        if (r_n == LAST_IDX) begin
                            r_phase <= EMIT;
                        end else begin
                            r_n <= r_n + IDX_W'(1);
                        end
                    end else begin
                        r_result       <= r_acc;
                        r_result_lag   <= r_k;
                        r_result_valid <= 1'b1;
                        r_acc          <= '0;
                        r_phase        <= MAC;
                        if (r_k == LAST_LAG) begin
                            r_state <= DONE;
                        end else begin
                            r_k <= r_k + LAG_W'(1);
                            r_n <= IDX_W'(r_k) + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_result       = r_result;
    assign o_result_lag   = r_result_lag;
    assign o_result_valid = r_result_valid;
    assign o_done         = r_done;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_autocorr_controller.sv
// tb_autocorr_controller
// Self-checking bench for autocorr_controller. Words are randomized, and the
// expected lag sums and pulse cycles are derived directly from the
// autocorrelation definition and the per-lag cycle budget (N-k+1).
module tb_autocorr_controller;

    localparam int N       = 8;
    localparam int MAX_LAG = 4;
    localparam int ACC_W   = 9;
    localparam int LAG_W   = 2;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [2:0]       i_word_in;
    logic             i_word_valid;
    logic             o_busy;
    logic [ACC_W-1:0] o_result;
    logic [LAG_W-1:0] o_result_lag;
    logic             o_result_valid;
    logic             o_done;
    logic             o_overrun;

    int testsRun;
    int testsFailed;

    logic [2:0] x [N];
    int   gotRes [$];
    int   gotLag [$];
    int   gotCyc [$];
    int   doneCyc;
    logic doneOverrun;
    logic doneBusy;
    int   doneResult;
    logic busyDropped;
    logic ovAfterStart;

    autocorr_controller #(
        .N       (N),
        .MAX_LAG (MAX_LAG),
        .ACC_W   (ACC_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_word_in      (i_word_in),
        .i_word_valid   (i_word_valid),
        .o_busy         (o_busy),
        .o_result       (o_result),
        .o_result_lag   (o_result_lag),
        .o_result_valid (o_result_valid),
        .o_done         (o_done),
        .o_overrun      (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: R[k] straight from the definition.
    function automatic int refR(input int k);
        int s;
        s = 0;
        for (int n = k; n < N; n++) begin
            s += int'(x[n]) * int'(x[n - k]);
        end
        return s;
    endfunction

    // Cycle (counted from the capture edge of the last word) of lag k's pulse.
    function automatic int expCycle(input int k);
        int c;
        c = 0;
        for (int j = 0; j <= k; j++) begin
            c += N - j + 1;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic randomWords(input int lo);
        for (int i = 0; i < N; i++) begin
            x[i] = 3'($urandom_range(lo, 7));
        end
    endtask

    // Issues start, then strobes in x[0..N-1]; optional extra strobe with
    // the start and optional idle gaps between words.
    task automatic applyStimulus(input bit coincident, input bit sparse);
        int gap;
        busyDropped = 1'b0;
        i_start = 1'b1;
        if (coincident) begin
            i_word_valid = 1'b1;
            i_word_in    = x[0] ^ 3'b101;
        end
        tick();
        i_start      = 1'b0;
        i_word_valid = 1'b0;
        ovAfterStart = o_overrun;
        for (int i = 0; i < N; i++) begin
            gap = sparse ? 2 + int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gap; g++) begin
                if (o_busy !== 1'b1) busyDropped = 1'b1;
                tick();
            end
            i_word_in    = x[i];
            i_word_valid = 1'b1;
            if (o_busy !== 1'b1) busyDropped = 1'b1;
            tick();
            i_word_valid = 1'b0;
        end
    endtask

    // Records every result pulse and the done pulse with its cycle index.
    task automatic collectRun(input int injectAt, input int startAt);
        gotRes.delete();
        gotLag.delete();
        gotCyc.delete();
        doneCyc     = -1;
        doneOverrun = 1'bx;
        doneBusy    = 1'bx;
        doneResult  = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == injectAt) begin
                i_word_valid = 1'b1;
                i_word_in    = 3'($urandom);
            end
            if (c == startAt) i_start = 1'b1;
            tick();
            i_word_valid = 1'b0;
            i_start      = 1'b0;
            if (o_result_valid === 1'b1) begin
                gotRes.push_back(int'(o_result));
                gotLag.push_back(int'(o_result_lag));
                gotCyc.push_back(c);
            end
            if (o_done === 1'b1) begin
                doneCyc     = c;
                doneOverrun = o_overrun;
                doneBusy    = o_busy;
                doneResult  = int'(o_result);
                break;
            end
        end
    endtask

    task automatic test_reset();
        testsRun++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: busy=%b rv=%b done=%b, want 0/0/0", o_busy, o_result_valid, o_done);
        end
        testsRun++;
        if (o_overrun !== 1'b0 || o_result !== '0 || o_result_lag !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: overrun=%b result=%0d lag=%0d, want 0/0/0", o_overrun, o_result, o_result_lag);
        end
    endtask

    task automatic test_constant();
        for (int i = 0; i < N; i++) x[i] = 3'd7;
        applyStimulus(1'b0, 1'b0);
        collectRun(0, 0);
        testsRun++;
        if (gotRes.size() != MAX_LAG || doneCyc != expCycle(MAX_LAG - 1) + 1) begin
            testsFailed++;
            $display("[TB] FAIL const_shape: pulses=%0d done_cycle=%0d, want %0d/%0d", gotRes.size(), doneCyc, MAX_LAG, expCycle(MAX_LAG - 1) + 1);
        end
        for (int k = 0; k < gotRes.size() && k < MAX_LAG; k++) begin
            testsRun++;
            if (gotRes[k] != 392 - 49 * k || gotLag[k] != k || gotCyc[k] != expCycle(k)) begin
                testsFailed++;
                $display("[TB] FAIL const_lag%0d: result=%0d lag=%0d cycle=%0d, want %0d/%0d/%0d", k, gotRes[k], gotLag[k], gotCyc[k], 392 - 49 * k, k, expCycle(k));
            end
        end
        testsRun++;
        if (doneOverrun !== 1'b0 || doneBusy !== 1'b0 || doneResult != 245) begin
            testsFailed++;
            $display("[TB] FAIL const_done: overrun=%b busy=%b held_result=%0d, want 0/0/245", doneOverrun, doneBusy, doneResult);
        end
    endtask

    task automatic test_alternating();
        for (int i = 0; i < N; i++) x[i] = (i % 2 == 0) ? 3'd1 : 3'd0;
        applyStimulus(1'b0, 1'b0);
        collectRun(0, 0);
        testsRun++;
        if (gotRes.size() != MAX_LAG || doneCyc < 0) begin
            testsFailed++;
            $display("[TB] FAIL alt_shape: pulses=%0d done_cycle=%0d, want %0d pulses and a done", gotRes.size(), doneCyc, MAX_LAG);
        end
        for (int k = 0; k < gotRes.size() && k < MAX_LAG; k++) begin
            testsRun++;
            if (gotRes[k] != refR(k) || gotLag[k] != k) begin
                testsFailed++;
                $display("[TB] FAIL alt_lag%0d: result=%0d lag=%0d, want %0d/%0d", k, gotRes[k], gotLag[k], refR(k), k);
            end
        end
    endtask

    task automatic test_random_sparse();
        for (int run = 0; run < 4; run++) begin
            randomWords(0);
            applyStimulus(1'b0, run[0]);
            collectRun(0, 0);
            testsRun++;
            if (busyDropped !== 1'b0 || gotRes.size() != MAX_LAG || doneCyc != expCycle(MAX_LAG - 1) + 1) begin
                testsFailed++;
                $display("[TB] FAIL rand%0d_shape: busy_dropped=%b pulses=%0d done_cycle=%0d, want 0/%0d/%0d", run, busyDropped, gotRes.size(), doneCyc, MAX_LAG, expCycle(MAX_LAG - 1) + 1);
            end
            for (int k = 0; k < gotRes.size() && k < MAX_LAG; k++) begin
                testsRun++;
                if (gotRes[k] != refR(k) || gotLag[k] != k || gotCyc[k] != expCycle(k)) begin
                    testsFailed++;
                    $display("[TB] FAIL rand%0d_lag%0d: result=%0d lag=%0d cycle=%0d, want %0d/%0d/%0d", run, k, gotRes[k], gotLag[k], gotCyc[k], refR(k), k, expCycle(k));
                end
            end
        end
    endtask

    task automatic test_overrun();
        randomWords(1);
        applyStimulus(1'b0, 1'b0);
        collectRun(int'($urandom_range(2, 28)), 0);
        testsRun++;
        if (doneOverrun !== 1'b1 || gotRes.size() != MAX_LAG) begin
            testsFailed++;
            $display("[TB] FAIL overrun_set: overrun_at_done=%b pulses=%0d, want 1/%0d", doneOverrun, gotRes.size(), MAX_LAG);
        end
        for (int k = 0; k < gotRes.size() && k < MAX_LAG; k++) begin
            testsRun++;
            if (gotRes[k] != refR(k)) begin
                testsFailed++;
                $display("[TB] FAIL overrun_lag%0d: result=%0d, want %0d", k, gotRes[k], refR(k));
            end
        end
        i_word_valid = 1'b1;
        tick();
        i_word_valid = 1'b0;
        testsRun++;
        if (o_overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_sticky_idle: overrun=%b, want 1", o_overrun);
        end
        randomWords(0);
        applyStimulus(1'b0, 1'b0);
        testsRun++;
        if (ovAfterStart !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL overrun_clear: overrun after start=%b, want 0", ovAfterStart);
        end
        collectRun(0, 0);
        testsRun++;
        if (doneOverrun !== 1'b0 || gotRes.size() != MAX_LAG || gotRes[0] != refR(0)) begin
            testsFailed++;
            $display("[TB] FAIL overrun_clean_run: overrun=%b pulses=%0d, want 0/%0d", doneOverrun, gotRes.size(), MAX_LAG);
        end
    endtask

    task automatic test_mid_reset();
        logic seen;
        logic stray;
        randomWords(1);
        applyStimulus(1'b0, 1'b0);
        seen = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (c == 3) i_word_valid = 1'b1;
            tick();
            i_word_valid = 1'b0;
            if (o_result_valid === 1'b1) seen = 1'b1;
        end
        testsRun++;
        if (seen !== 1'b1 || o_result != ACC_W'(refR(0)) || o_overrun !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_lag0: seen=%b result=%0d overrun=%b, want 1/%0d/1", seen, o_result, o_overrun, refR(0));
        end
        i_rst_n = 1'b0;
        tick();
        testsRun++;
        if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_done !== 1'b0 || o_overrun !== 1'b0 || o_result !== '0 || o_result_lag !== '0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_outputs: busy=%b rv=%b done=%b ov=%b result=%0d lag=%0d, want all 0", o_busy, o_result_valid, o_done, o_overrun, o_result, o_result_lag);
        end
        i_rst_n = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_result_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) stray = 1'b1;
        end
        testsRun++;
        if (stray !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_quiet: activity after reset=%b, want 0", stray);
        end
        randomWords(0);
        applyStimulus(1'b0, 1'b0);
        collectRun(0, 0);
        for (int k = 0; k < MAX_LAG; k++) begin
            testsRun++;
            if (k >= gotRes.size() || gotRes[k] != refR(k)) begin
                testsFailed++;
                $display("[TB] FAIL midrst_rerun_lag%0d: got %0d pulses, want result %0d", k, gotRes.size(), refR(k));
            end
        end
    endtask

    task automatic test_start_ignored();
        randomWords(1);
        applyStimulus(1'b1, 1'b0);
        collectRun(0, 12);
        testsRun++;
        if (gotRes.size() != MAX_LAG || doneCyc != expCycle(MAX_LAG - 1) + 1) begin
            testsFailed++;
            $display("[TB] FAIL startign_shape: pulses=%0d done_cycle=%0d, want %0d/%0d", gotRes.size(), doneCyc, MAX_LAG, expCycle(MAX_LAG - 1) + 1);
        end
        for (int k = 0; k < gotRes.size() && k < MAX_LAG; k++) begin
            testsRun++;
            if (gotRes[k] != refR(k) || gotCyc[k] != expCycle(k)) begin
                testsFailed++;
                $display("[TB] FAIL startign_lag%0d: result=%0d cycle=%0d, want %0d/%0d", k, gotRes[k], gotCyc[k], refR(k), expCycle(k));
            end
        end
        tick();
        tick();
        testsRun++;
        if (o_busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL startign_idle: busy=%b after done, want 0", o_busy);
        end
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_word_in    = '0;
        i_word_valid = 1'b0;
        tick();
        tick();
        tick();
        test_reset();
        i_rst_n = 1'b1;
        tick();
        test_constant();
        test_alternating();
        test_random_sparse();
        test_overrun();
        test_mid_reset();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/autocorr_controller.md
# autocorr_controller

Sequences one autocorrelation run over the 3-bit words produced by the serial-to-parallel front end. On `start` it captures `N` consecutive words, qualified by the front end's word strobe, into an internal window. It then computes lags R[0..MAX_LAG-1] with a single time-shared multiply-accumulate unit and streams each lag result out with a one-cycle valid. It sits between the deserializer and the result/display logic of the correlator.

## Interface
- `N`, 8: window length in words; must be ≥ 2.
- `MAX_LAG`, 4: number of lags computed; 1 ≤ MAX_LAG ≤ N.
- `ACC_W`, 2*SAMPLE_W + $clog2(N): accumulator/result width; guarantees no overflow.
- `clk`  in  1: sole clock; all logic on rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: begin a run; sampled only in IDLE.
- `word_in`  in  SAMPLE_W (3): unsigned sample from the deserializer.
- `word_valid`  in  1: one-cycle strobe marking `word_in` valid.
- `busy`  out  1: high in FILL and COMPUTE.
- `result`  out  ACC_W: R[k] for the lag currently presented.
- `result_lag`  out  $clog2(MAX_LAG) (min 1): lag index k of `result`.
- `result_valid`  out  1: one-cycle pulse per lag.
- `done`  out  1: one-cycle pulse after the last lag.
- `overrun`  out  1: sticky; a `word_valid` arrived during COMPUTE.

## Operation
- R[k] = sum over n = k..N-1 of x[n]*x[n-k], unsigned; x[0] is the first word captured after `start`.
- States:
  - IDLE: `start`=1 → FILL; write pointer := 0; `overrun` cleared.
  - FILL: each `word_valid` stores `word_in` at the pointer and increments it. The store of word N-1 → COMPUTE with k := 0, n := 0, acc := 0. Cycles without `word_valid` wait indefinitely.
  - COMPUTE, MAC sub-phase: one product per cycle, acc += x[n]*x[n-k], for n = k..N-1 (N-k cycles).
  - COMPUTE, EMIT sub-phase: one cycle after the last product. `result` := acc, `result_lag` := k, `result_valid` = 1. Then acc := 0.
    - If k = MAX_LAG-1 → DONE.
    - Otherwise k := k+1 and n := k+1, returning to MAC.
  - DONE: `done` = 1 for one cycle → IDLE.
- `word_valid` in COMPUTE: word dropped, buffer unchanged, `overrun` := 1 (held until next accepted `start` or reset). `word_valid` in IDLE or DONE: ignored, no overrun.
- `start` outside IDLE: ignored.
- `word_valid` and the FILL entry cycle: a strobe in the same cycle as the accepted `start` is not captured; capture begins the following cycle.
- Buffer contents persist after DONE; they are overwritten by the next run.

## Timing
- Reset values: `busy`, `result_valid`, `done`, `overrun` = 0; `result` = 0; `result_lag` = 0; state IDLE; pointers/acc 0.
- Reset asserted mid-run: all state returns to reset values at that edge. No `result_valid` or `done` is emitted for the aborted run.
- `busy` rises the cycle after the accepted `start` and falls the cycle `done` is high.
- Compute latency from the FILL→COMPUTE edge to the `done` pulse: sum over k = 0..MAX_LAG-1 of (N-k+1) cycles, plus 1 cycle. For N=8, MAX_LAG=4 the `result_valid` pulses are on cycles 9, 17, 24, 30; `done` is on cycle 31.
- `result`/`result_lag` hold their last emitted values between pulses.

## Structure
- Package `autocorr_pkg`:
  - `SAMPLE_W` = 3.
  - State enum `state_t` {IDLE, FILL, COMPUTE, DONE}.
  - Sub-phase enum {MAC, EMIT}.
- Sub-module `autocorr_sample_buf`: N×SAMPLE_W register file with one synchronous write port. It has two combinational read ports, addressed n and n-k, which feed the MAC.
- Controller FSM, counters and accumulator live in `autocorr_controller`.

## Test plan
- Constant samples, N=8, MAX_LAG=4: eight words of 7 → `result` = 392, 343, 294, 245 with `result_lag` 0..3, pulses on cycles 9/17/24/30, `done` on cycle 31, no overrun.
- Alternating samples: 1,0,1,0,1,0,1,0 → R = 4, 0, 3, 0.
- Sparse strobes: `word_valid` spaced 3 cycles apart (the deserializer cadence) with random gaps → results identical to the back-to-back case; `busy` high throughout FILL.
- Overrun: a strobe injected during COMPUTE → `overrun` = 1 and stays set through `done`. Results are unchanged, and `overrun` clears on the next `start`.
- Mid-run reset: `rst_n` = 0 during COMPUTE after the lag-0 result → all outputs 0 the next cycle, no further `result_valid`. A new run afterwards produces correct results.
- `start` while `busy`, and `start` coincident with `word_valid`: both ignored as specified. The first captured word is the next strobe.
